// File: rtl/sp_sram_pkg.sv
// ---------------------------------------------------------------------------
// sp_sram_pkg
//   Shared types and helpers for the pipelined single-port SRAM model.
//   - sram_state_e     : init/clear FSM states
//   - MAX_READ_LATENCY : deepest supported read pipeline
//   - byte_parity()    : even-parity bit for one byte
// ---------------------------------------------------------------------------
package sp_sram_pkg;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } sram_state_e;

   localparam int unsigned MAX_READ_LATENCY = 4;

   // Even parity: stored bit makes the total number of ones (byte + bit) even.
   function automatic logic byte_parity(input logic [7:0] b);
      return ^b;
   endfunction

endpackage

// File: rtl/sp_sram_rd_pipe.sv
// ---------------------------------------------------------------------------
// sp_sram_rd_pipe
//   LATENCY-deep read-return shift register. Valid bits shift every cycle;
//   data/user/err of a stage only load when the stage feeding it is valid,
//   so the output holds the last valid beat while out_valid is low.
//   Ports:
//     clk_i, rst_ni       clock, synchronous active-low reset
//     in_valid/in_data/in_user/in_err      beat entering stage 1
//     out_valid/out_data/out_user/out_err  beat leaving the last stage
//                                          (out_err gated by out_valid)
// ---------------------------------------------------------------------------
module sp_sram_rd_pipe #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned USER_WIDTH = 1,
   parameter int unsigned LATENCY    = 1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic [USER_WIDTH-1:0] in_user,
   input  logic                  in_err,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [USER_WIDTH-1:0] out_user,
   output logic                  out_err
);

   localparam int unsigned LAST = LATENCY - 1;

   logic                  valid_q [LATENCY];
   logic [DATA_WIDTH-1:0] data_q  [LATENCY];
   logic [USER_WIDTH-1:0] user_q  [LATENCY];
   logic                  err_q   [LATENCY];

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < LATENCY; i++) begin
            valid_q[i] <= 1'b0;
            data_q[i]  <= '0;
            user_q[i]  <= '0;
            err_q[i]   <= 1'b0;
         end
      end else begin
         valid_q[0] <= in_valid;
         if (in_valid) begin
            data_q[0] <= in_data;
            user_q[0] <= in_user;
            err_q[0]  <= in_err;
         end
         for (int unsigned i = 1; i < LATENCY; i++) begin
            valid_q[i] <= valid_q[i-1];
            if (valid_q[i-1]) begin
               data_q[i] <= data_q[i-1];
               user_q[i] <= user_q[i-1];
               err_q[i]  <= err_q[i-1];
            end
         end
      end
   end

   assign out_valid = valid_q[LAST];
   assign out_data  = data_q[LAST];
   assign out_user  = user_q[LAST];
   assign out_err   = valid_q[LAST] & err_q[LAST];

endmodule

// File: rtl/sp_sram_pipe.sv
// ---------------------------------------------------------------------------
// sp_sram_pipe
//   Single-port SRAM model with req/gnt/rvalid handshake, configurable read
//   latency (1..4) and a post-reset clear sequence that zeroes every word.
//   A user sideband word is stored alongside each data word.
//   Optional feature (define SP_SRAM_PARITY_EN): per-byte even parity plus one
//   bit over the user word, checked on read and reported on err_o.
//   Ports:
//     clk_i, rst_ni    clock, synchronous active-low reset
//     req_i, gnt_o     request / grant (gnt_o = state is READY)
//     we_i             1 = write, 0 = read
//     addr_i           word address
//     wdata_i, be_i    write data and byte enables
//     wuser_i          sideband written on every write (independent of be_i)
//     rvalid_o         read beat valid, READ_LATENCY cycles after accept
//     rdata_o, ruser_o read data / sideband (hold last beat)
//     init_done_o      clear sequence finished
//     err_o            parity error on current beat (0 without parity)
// ---------------------------------------------------------------------------
module sp_sram_pipe
   import sp_sram_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned NUM_WORDS      = 1024,
   parameter int unsigned USER_WIDTH     = 1,
   parameter int unsigned READ_LATENCY   = 1,
   parameter bit          CLEAR_ON_RESET = 1'b1,
   parameter int unsigned ADDR_WIDTH     = $clog2(NUM_WORDS)
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    req_i,
   output logic                    gnt_o,
   input  logic                    we_i,
   input  logic [ADDR_WIDTH-1:0]   addr_i,
   input  logic [DATA_WIDTH-1:0]   wdata_i,
   input  logic [DATA_WIDTH/8-1:0] be_i,
   input  logic [USER_WIDTH-1:0]   wuser_i,
   output logic                    rvalid_o,
   output logic [DATA_WIDTH-1:0]   rdata_o,
   output logic [USER_WIDTH-1:0]   ruser_o,
   output logic                    init_done_o,
   output logic                    err_o
);

   localparam int unsigned NUM_BYTES  = DATA_WIDTH / 8;
   localparam int unsigned PIPE_DEPTH = (READ_LATENCY < 1) ? 1 :
                                        (READ_LATENCY > MAX_READ_LATENCY) ? MAX_READ_LATENCY :
                                        READ_LATENCY;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);

   sram_state_e           state_q, state_d;
   logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
   logic                  init_done_q;
   logic                  clr_en, wr_en, rd_en;
   logic                  rd_err;

   logic [DATA_WIDTH-1:0] mem_data [NUM_WORDS];
   logic [USER_WIDTH-1:0] mem_user [NUM_WORDS];

   // ---------------- clear FSM ----------------
   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      gnt_o     = 1'b0;
      clr_en    = 1'b0;
      wr_en     = 1'b0;
      rd_en     = 1'b0;
      case (state_q)
         ST_CLEAR: begin
            clr_en    = rst_ni;
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == LAST_ADDR) begin
               state_d = ST_READY;
            end
         end
         ST_READY: begin
            gnt_o = 1'b1;
            // Array updates are suppressed on a reset edge; the read pipe is
            // cleared by its own reset so rd_en needs no gating.
            wr_en = req_i & we_i & rst_ni;
            rd_en = req_i & ~we_i;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q     <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
         clr_cnt_q   <= '0;
         init_done_q <= !CLEAR_ON_RESET;
      end else begin
         state_q     <= state_d;
         clr_cnt_q   <= clr_cnt_d;
         init_done_q <= (state_d == ST_READY);
      end
   end

   assign init_done_o = init_done_q;

   // ---------------- storage ----------------
   always_ff @(posedge clk_i) begin
      if (clr_en) begin
         mem_data[clr_cnt_q] <= '0;
         mem_user[clr_cnt_q] <= '0;
      end else if (wr_en) begin
         for (int unsigned b = 0; b < NUM_BYTES; b++) begin
            if (be_i[b]) begin
               mem_data[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
         end
         mem_user[addr_i] <= wuser_i;
      end
   end

`ifdef SP_SRAM_PARITY_EN
   // Bit NUM_BYTES covers the user word; lower bits cover data bytes.
   logic [NUM_BYTES:0] mem_par [NUM_WORDS];
   logic [NUM_BYTES:0] rd_par_calc;

   always_ff @(posedge clk_i) begin
      if (clr_en) begin
         mem_par[clr_cnt_q] <= '0;
      end else if (wr_en) begin
         for (int unsigned b = 0; b < NUM_BYTES; b++) begin
            if (be_i[b]) begin
               mem_par[addr_i][b] <= byte_parity(wdata_i[b*8 +: 8]);
            end
         end
         mem_par[addr_i][NUM_BYTES] <= ^wuser_i;
      end
   end

   always_comb begin
      rd_par_calc = '0;
      for (int unsigned b = 0; b < NUM_BYTES; b++) begin
         rd_par_calc[b] = byte_parity(mem_data[addr_i][b*8 +: 8]);
      end
      rd_par_calc[NUM_BYTES] = ^mem_user[addr_i];
      rd_err = (rd_par_calc != mem_par[addr_i]);
   end
`else
   assign rd_err = 1'b0;
`endif

   // ---------------- read return pipeline ----------------
   sp_sram_rd_pipe #(
      .DATA_WIDTH (DATA_WIDTH),
      .USER_WIDTH (USER_WIDTH),
      .LATENCY    (PIPE_DEPTH)
   ) u_rd_pipe (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .in_valid  (rd_en),
      .in_data   (mem_data[addr_i]),
      .in_user   (mem_user[addr_i]),
      .in_err    (rd_err),
      .out_valid (rvalid_o),
      .out_data  (rdata_o),
      .out_user  (ruser_o),
      .out_err   (err_o)
   );

endmodule
